// File: rtl/byte_mem_ctrl.sv
// Byte-addressed data memory with a start/ready handshake, byte-lane write enables,
// address-dependent access latency and combinational test read ports.
module byte_mem_ctrl #(
  parameter int DATA_BYTES    = 4,
  parameter int DEPTH         = 256,
  parameter int ADDR_W        = 32,
  parameter int BASE_LAT      = 0,
  parameter int ALIGN_PENALTY = 1,
  parameter int NUM_TEST      = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             rwn,
  input  logic [ADDR_W-1:0]                address,
  input  logic [8*DATA_BYTES-1:0]          data_in,
  input  logic [DATA_BYTES-1:0]            byte_en,
  output logic [8*DATA_BYTES-1:0]          data_out,
  output logic                             ready,
  output logic                             done,
  input  logic [NUM_TEST*ADDR_W-1:0]       test_addr,
  output logic [NUM_TEST*8*DATA_BYTES-1:0] test_data
);

  localparam int DW    = 8 * DATA_BYTES;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(BASE_LAT + DATA_BYTES) + 1;

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < DATA_BYTES)) begin : gBadDepth
    $error("byte_mem_ctrl: DEPTH must be a power of two and at least DATA_BYTES");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t             stateQ, stateD;
  logic [CNT_W-1:0]   cntQ, cntD;
  logic               acceptReq;
  logic [31:0]        nReq;
  logic [AW-1:0]      addrQ;
  logic               rwnQ;
  logic [DW-1:0]      dataQ;
  logic [DATA_BYTES-1:0] beQ;
  logic [DW-1:0]      dataOutQ;
  logic               doneQ;
  logic [7:0]         memQ [DEPTH];
  logic [AW-1:0]      laneAddr [DATA_BYTES];

  // Wait cycles for the request currently presented; misaligned words cost extra.
  always_comb begin
    nReq = 32'(BASE_LAT);
    if (ALIGN_PENALTY != 0) begin
      nReq = nReq + (32'(address[AW-1:0]) % 32'(DATA_BYTES));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= S_IDLE;
      cntQ   <= '0;
      doneQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      doneQ  <= (stateQ == S_ACCESS);
    end
  end

  // WAIT leaves when the counter is about to hit zero so the access lands at T+1+N.
  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    acceptReq = 1'b0;
    case (stateQ)
      S_IDLE: begin
        if (start) begin
          acceptReq = 1'b1;
          cntD      = CNT_W'(nReq);
          stateD    = (nReq != 32'd0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cntD = cntQ - CNT_W'(1);
        if (cntQ == CNT_W'(1)) begin
          stateD = S_ACCESS;
        end
      end
      S_ACCESS: begin
        stateD = S_IDLE;
      end
      default: begin
        stateD = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrQ <= '0;
      rwnQ  <= 1'b1;
      dataQ <= '0;
      beQ   <= '0;
    end else if (acceptReq) begin
      addrQ <= address[AW-1:0];
      rwnQ  <= rwn;
      dataQ <= data_in;
      beQ   <= byte_en;
    end
  end

  always_comb begin
    for (int i = 0; i < DATA_BYTES; i++) begin
      laneAddr[i] = addrQ + AW'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOutQ <= '0;
    end else if ((stateQ == S_ACCESS) && rwnQ) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        dataOutQ[8*i +: 8] <= memQ[laneAddr[i]];
      end
    end
  end

  // Reset clears the whole array, which also guarantees an aborted write leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        memQ[i] <= '0;
      end
    end else if ((stateQ == S_ACCESS) && !rwnQ) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (beQ[i]) begin
          memQ[laneAddr[i]] <= dataQ[8*i +: 8];
        end
      end
    end
  end

  assign ready    = (stateQ == S_IDLE);
  assign done     = doneQ;
  assign data_out = dataOutQ;

  for (genvar k = 0; k < NUM_TEST; k++) begin : gTest
    logic [AW-1:0] baseAddr;
    assign baseAddr = test_addr[k*ADDR_W +: AW];
    for (genvar i = 0; i < DATA_BYTES; i++) begin : gLane
      assign test_data[k*DW + 8*i +: 8] = memQ[baseAddr + AW'(i)];
    end
    if (ADDR_W > AW) begin : gHi
      logic unusedTestHi;
      assign unusedTestHi = ^test_addr[k*ADDR_W + AW +: ADDR_W - AW];
    end
  end

  if (ADDR_W > AW) begin : gAddrHi
    logic unusedAddrHi;
    assign unusedAddrHi = ^address[ADDR_W-1:AW];
  end

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Self-checking bench for byte_mem_ctrl: directed scenarios plus randomized traffic
// compared against a byte-array reference model of the memory.
module tb_byte_mem_ctrl;

  localparam int DATA_BYTES    = 4;
  localparam int DEPTH         = 256;
  localparam int ADDR_W        = 32;
  localparam int BASE_LAT      = 0;
  localparam int ALIGN_PENALTY = 1;
  localparam int NUM_TEST      = 3;
  localparam int DW            = 8 * DATA_BYTES;

  logic                      clk;
  logic                      reset;
  logic                      start;
  logic                      rwn;
  logic [ADDR_W-1:0]         address;
  logic [DW-1:0]             data_in;
  logic [DATA_BYTES-1:0]     byte_en;
  logic [DW-1:0]             data_out;
  logic                      ready;
  logic                      done;
  logic [NUM_TEST*ADDR_W-1:0] test_addr;
  logic [NUM_TEST*DW-1:0]    test_data;

  byte_mem_ctrl #(
    .DATA_BYTES(DATA_BYTES), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .BASE_LAT(BASE_LAT), .ALIGN_PENALTY(ALIGN_PENALTY), .NUM_TEST(NUM_TEST)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rwn(rwn), .address(address),
    .data_in(data_in), .byte_en(byte_en), .data_out(data_out), .ready(ready),
    .done(done), .test_addr(test_addr), .test_data(test_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;
  logic [7:0]    model [DEPTH];
  logic [DW-1:0] modelOut;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] modelWord(input int unsigned a);
    logic [DW-1:0] w;
    for (int i = 0; i < DATA_BYTES; i++) begin
      w[8*i +: 8] = model[(a + i) % DEPTH];
    end
    return w;
  endfunction

  task automatic checkTestPorts(input int unsigned a0, input int unsigned a1, input int unsigned a2);
    int unsigned addrs [NUM_TEST];
    addrs[0] = a0;
    addrs[1] = a1;
    addrs[2] = a2;
    for (int k = 0; k < NUM_TEST; k++) begin
      test_addr[k*ADDR_W +: ADDR_W] = addrs[k];
    end
    #1;
    for (int k = 0; k < NUM_TEST; k++) begin
      checkOutput($sformatf("test_data%0d@%0h", k, addrs[k]), 64'(test_data[k*DW +: DW]),
                  64'(modelWord(addrs[k])));
    end
  endtask

  // One request with cycle-exact checks of ready/done and the final result.
  task automatic applyStimulus(input logic rd, input int unsigned a, input logic [DW-1:0] d,
                               input logic [DATA_BYTES-1:0] be, input bit busyPulse);
    int n;
    n = BASE_LAT + ((ALIGN_PENALTY != 0) ? int'((a % DEPTH) % DATA_BYTES) : 0);
    checkOutput("idle_ready", 64'(ready), 64'd1);
    start   = 1'b1;
    rwn     = rd;
    address = a;
    data_in = d;
    byte_en = be;
    @(posedge clk); #1;
    start = 1'b0;
    if (rd) begin
      modelOut = modelWord(a);
    end else begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (be[i]) model[(a + i) % DEPTH] = d[8*i +: 8];
      end
    end
    for (int j = 0; j <= n; j++) begin
      checkOutput($sformatf("busy_ready_c%0d", j), 64'(ready), 64'd0);
      checkOutput($sformatf("busy_done_c%0d", j), 64'(done), 64'd0);
      address = $urandom;
      data_in = $urandom;
      byte_en = DATA_BYTES'($urandom);
      rwn     = 1'($urandom);
      start   = busyPulse && (j == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checkOutput("end_ready", 64'(ready), 64'd1);
    checkOutput("end_done", 64'(done), 64'd1);
    checkOutput("data_out", 64'(data_out), 64'(modelOut));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    rwn       = 1'b1;
    address   = '0;
    data_in   = '0;
    byte_en   = '0;
    test_addr = '0;
    modelOut  = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    checkOutput("reset_ready", 64'(ready), 64'd1);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_data_out", 64'(data_out), 64'd0);
    checkTestPorts(32'h0, 32'h10, 32'hFE);

    // Aligned write then read back.
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0);
    checkTestPorts(32'h10, 32'h0C, 32'h14);
    applyStimulus(1'b1, 32'h10, 32'h0, 4'b0000, 1'b0);
    checkOutput("aligned_read", 64'(data_out), 64'hDEADBEEF);

    // Misaligned read: three wait cycles.
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'h13, 32'h0, 4'b0000, 1'b0);
    checkOutput("misaligned_read", 64'(data_out), 64'h000000DE);

    // Write wrapping past the top of memory.
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'hFE, 32'h11223344, 4'b1111, 1'b0);
    checkTestPorts(32'hFE, 32'h00, 32'hFC);
    checkOutput("wrap_word", 64'(test_data[0 +: DW]), 64'h11223344);

    // Byte-lane merge with an ignored start pulse while busy.
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h20, 32'h12345678, 4'b1111, 1'b0);
    applyStimulus(1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1);
    @(posedge clk); #1;
    checkOutput("no_extra_done", 64'(done), 64'd0);
    checkOutput("no_extra_busy", 64'(ready), 64'd1);
    applyStimulus(1'b1, 32'h20, 32'h0, 4'b0000, 1'b0);
    checkOutput("lane_merge", 64'(data_out), 64'h12BB56DD);

    // Reset during WAIT of a write to 0x03 aborts it and clears everything.
    @(posedge clk); #1;
    start   = 1'b1;
    rwn     = 1'b0;
    address = 32'h03;
    data_in = 32'hCAFEF00D;
    byte_en = 4'hF;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("abort_busy", 64'(ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_ready", 64'(ready), 64'd1);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_data_out", 64'(data_out), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    modelOut = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("abort_no_done_c%0d", c), 64'(done), 64'd0);
    end
    for (int unsigned a = 0; a < DEPTH; a += 12) begin
      checkTestPorts(a, a + 4, a + 8);
    end

    // Randomized traffic, including upper address bits that must be ignored.
    @(posedge clk); #1;
    for (int t = 0; t < 60; t++) begin
      int unsigned a;
      a = $urandom;
      applyStimulus(1'($urandom), a, $urandom, DATA_BYTES'($urandom), ($urandom % 4) == 0);
      checkTestPorts(a, $urandom, $urandom);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/byte_mem_ctrl.md
Name: byte_mem_ctrl

Overview:
Parametrised byte-addressed data memory with a start/ready request handshake and address-dependent access latency.
- Byte-lane write enables, configurable word width, depth and base latency, a done pulse, and a configurable number of combinational test read ports.
- Serves as the main memory model behind the datapath controller; the bench also uses the test ports to inspect memory.

Parameters:
DATA_BYTES, 4, bytes per word; data width = 8*DATA_BYTES.
DEPTH, 256, memory size in bytes; power of two, at least DATA_BYTES.
ADDR_W, 32, request and test address width; only the low log2(DEPTH) bits are used.
BASE_LAT, 0, fixed extra wait cycles added to every access.
ALIGN_PENALTY, 1, when 1, adds (address mod DATA_BYTES) wait cycles; when 0, adds none.
NUM_TEST, 3, number of combinational test read ports.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  request strobe; sampled only while ready=1
rwn  in  1  1 = read, 0 = write
address  in  ADDR_W  byte address of the word's lowest byte
data_in  in  8*DATA_BYTES  write data, little-endian
byte_en  in  DATA_BYTES  write lane enables; bit i controls byte i
data_out  out  8*DATA_BYTES  registered read data
ready  out  1  1 = idle and able to accept a request
done  out  1  one-cycle pulse after an access completes
test_addr  in  NUM_TEST*ADDR_W  packed test addresses; port k uses slice k
test_data  out  NUM_TEST*8*DATA_BYTES  packed combinational reads of the test addresses

Behaviour:
- Reset (asynchronous): state=IDLE, ready=1, done=0, data_out=0, all DEPTH bytes=0, counter=0. No preload.
- Addressing:
  - Word byte i lives at (A + i) mod DEPTH, where A = address[log2(DEPTH)-1:0].
  - Byte i maps to data bits [8i+7:8i].
  - Accesses wrap past DEPTH-1 to 0.
- States:
  - IDLE: ready=1. On an edge with start=1, latch A, rwn, data_in and byte_en. Load counter with N = BASE_LAT + (ALIGN_PENALTY ? A mod DATA_BYTES : 0). Go to WAIT if N>0, else ACCESS.
  - WAIT: decrement counter each edge. When counter reaches 0, go to ACCESS.
  - ACCESS: perform the access on one edge.
    - Read: data_out is loaded with the word.
    - Write: byte i is written only where the latched byte_en[i]=1; bytes with byte_en[i]=0 are unchanged.
    - Then go to IDLE and set done=1 for exactly that next cycle.
- Latency: for a request accepted at edge T, the access occurs at edge T+1+N.
  - ready is low from after edge T through edge T+1+N.
  - ready returns high in the same cycle done is high.
- Request rules:
  - start while ready=0 is ignored; inputs are not re-sampled.
  - Minimum spacing between two accepted requests is N+2 edges.
  - A start held high is accepted again on the first edge with ready=1.
- Outputs:
  - data_out changes only on a read ACCESS edge. It holds across writes and idle cycles.
  - byte_en is ignored on reads.
  - Inputs that change after acceptance do not affect the in-flight request.
- Test ports: test_data slice k = the word at test_addr slice k, using the same wrap rule. Purely combinational; reflects a write in the cycle after its ACCESS edge.
- Reset mid-operation: the in-flight request is aborted, no partial write occurs, and the memory is cleared. done stays 0.
- Elaboration: DEPTH not a power of two, or DEPTH < DATA_BYTES, is an elaboration error.

Test Plan:
1. Reset release with defaults -> ready=1, done=0, data_out=0, all test_data=0.
2. Aligned write: address 0x10, data 0xDEADBEEF, byte_en 1111, accepted at edge T.
   - Write occurs at T+1; ready is low for 1 cycle; done pulses at T+1.
   - Read of 0x10 then returns 0xDEADBEEF two edges after its start.
   - test_data at 0x10 = 0xDEADBEEF.
3. Misaligned read of 0x13 (ALIGN_PENALTY=1) -> N=3; ready is low for 4 cycles; data_out updates at T+4 with bytes 0x13..0x16 little-endian.
4. Wrap write: address 0xFE, data 0x11223344 -> bytes 0xFE=44, 0xFF=33, 0x00=22, 0x01=11. test_data at 0xFE = 0x11223344.
5. Byte-lane write of 0xAABBCCDD with byte_en 0101 over 0x12345678 at 0x20 -> word reads 0x12BB56DD. A start pulsed while busy is ignored, so exactly one done is observed.
6. Reset asserted during WAIT of a write to 0x03 -> ready=1 immediately, no done, memory all zero, data_out=0.
